// File: rtl/issue_scoreboard_pkg.sv
// Shared types for the issue scoreboard: opcodes, FSM states and the
// opcode classifier that says which operands an instruction touches.
package issue_scoreboard_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   typedef enum logic [4:0] {
      OP_NOP,
      OP_ADD,
      OP_SUB,
      OP_ADDI,
      OP_LUI,
      OP_LOAD,
      OP_STORE,
      OP_BRANCH,
      OP_JAL,
      OP_JALR,
      OP_FENCE,
      OP_CSRRW,
      OP_CSRRS,
      OP_CSRRC,
      OP_ECALL,
      OP_EBREAK,
      OP_MRET
   } opcodes_t;

   typedef enum logic [1:0] {
      SB_RUN,
      SB_DRAIN,
      SB_SERIAL,
      SB_TRAP
   } sb_state_t;

   typedef struct packed {
      logic reads_rs1;
      logic reads_rs2;
      logic writes_rd;
      logic serial;
   } op_class_t;

   // Serial ops still read/write registers so the pending table stays consistent.
   function automatic op_class_t op_classify(input opcodes_t op);
      op_class_t c;
      c = '0;
      case (op)
         OP_ADD, OP_SUB: begin
            c.reads_rs1 = 1'b1;
            c.reads_rs2 = 1'b1;
            c.writes_rd = 1'b1;
         end
         OP_ADDI, OP_LOAD, OP_JALR: begin
            c.reads_rs1 = 1'b1;
            c.writes_rd = 1'b1;
         end
         OP_LUI, OP_JAL: begin
            c.writes_rd = 1'b1;
         end
         OP_STORE, OP_BRANCH: begin
            c.reads_rs1 = 1'b1;
            c.reads_rs2 = 1'b1;
         end
         OP_CSRRW, OP_CSRRS, OP_CSRRC: begin
            c.reads_rs1 = 1'b1;
            c.writes_rd = 1'b1;
            c.serial    = 1'b1;
         end
         OP_FENCE, OP_ECALL, OP_EBREAK, OP_MRET: begin
            c.serial = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/issue_scoreboard_pending_table.sv
// Per-register pending-write counters: one increment and one decrement per
// cycle, two operand read ports, all reads see the pre-update values.
module sb_pending_table
   import issue_scoreboard_pkg::*;
#(
   parameter int CNT_W = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  clr,
   input  logic [REG_ADDR_W-1:0] rd_addr_a,
   input  logic [REG_ADDR_W-1:0] rd_addr_b,
   output logic [CNT_W-1:0]      rd_data_a,
   output logic [CNT_W-1:0]      rd_data_b,
   input  logic                  inc_en,
   input  logic [REG_ADDR_W-1:0] inc_addr,
   output logic                  inc_full,
   input  logic                  dec_en,
   input  logic [REG_ADDR_W-1:0] dec_addr,
   output logic                  dec_empty
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0]    cnt_q [NUM_REGS];
   logic [CNT_W-1:0]    cnt_d [NUM_REGS];
   logic [NUM_REGS-1:0] inc_hit;
   logic [NUM_REGS-1:0] dec_hit;

   assign rd_data_a = cnt_q[rd_addr_a];
   assign rd_data_b = cnt_q[rd_addr_b];
   assign inc_full  = (cnt_q[inc_addr] == CNT_MAX);
   assign dec_empty = (cnt_q[dec_addr] == '0);

   // Saturating update; a matching inc/dec on one entry cancels out.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         inc_hit[i] = inc_en && (inc_addr == REG_ADDR_W'(i)) && (cnt_q[i] != CNT_MAX);
         dec_hit[i] = dec_en && (dec_addr == REG_ADDR_W'(i)) && (cnt_q[i] != '0);
         cnt_d[i]   = cnt_q[i];
         if (clr || (i == 0)) begin
            cnt_d[i] = '0;
         end else begin
            case ({inc_hit[i], dec_hit[i]})
               2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
               2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
               default: cnt_d[i] = cnt_q[i];
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            cnt_q[i] <= '0;
         end
      end else if (en) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue controller: gates decoded instructions on register hazards and the
// in-flight limit, serialises system ops and raises the illegal-op trap.
module issue_scoreboard
   import issue_scoreboard_pkg::*;
#(
   parameter int MAX_INFLIGHT = 4,
   parameter int CNT_W        = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              clk_en,
   input  logic                              dec_valid,
   input  opcodes_t                          dec_opcode,
   input  logic [REG_ADDR_W-1:0]             dec_rs1,
   input  logic [REG_ADDR_W-1:0]             dec_rs2,
   input  logic [REG_ADDR_W-1:0]             dec_rd,
   input  logic                              dec_illegal,
   input  logic                              exe_ready,
   output logic                              issue_valid,
   output logic                              o_busy,
   input  logic                              ret_valid,
   input  logic                              ret_we,
   input  logic [REG_ADDR_W-1:0]             ret_rd,
   input  logic                              flush,
   output logic                              trap_illegal,
   output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
   output logic                              sb_error
);

   localparam int INFL_W = $clog2(MAX_INFLIGHT + 1);

   sb_state_t         state_q, state_d;
   logic              drain_ill_q, drain_ill_d;
   logic [INFL_W-1:0] inflight_q, inflight_d;
   logic              sb_error_q, sb_error_d;

   op_class_t         cls;
   logic [CNT_W-1:0]  cnt_rs1;
   logic [CNT_W-1:0]  cnt_rs2;
   logic              rd_full;
   logic              ret_empty;
   logic              active;
   logic              at_limit;
   logic              hazard;
   logic              issue_fire;
   logic              trap_fire;
   logic              retire_ok;
   logic              inc_en;
   logic              dec_en;

   assign cls    = op_classify(dec_opcode);
   assign active = clk_en & ~rst & ~flush;

   sb_pending_table #(
      .CNT_W(CNT_W)
   ) u_pending (
      .clk       (clk),
      .rst       (rst),
      .en        (clk_en),
      .clr       (flush),
      .rd_addr_a (dec_rs1),
      .rd_addr_b (dec_rs2),
      .rd_data_a (cnt_rs1),
      .rd_data_b (cnt_rs2),
      .inc_en    (inc_en),
      .inc_addr  (dec_rd),
      .inc_full  (rd_full),
      .dec_en    (dec_en),
      .dec_addr  (ret_rd),
      .dec_empty (ret_empty)
   );

   // Hazards use pre-update counters, so a same-cycle retire never bypasses.
   always_comb begin
      at_limit   = (inflight_q == INFL_W'(MAX_INFLIGHT));
      hazard     = (cls.reads_rs1 & (cnt_rs1 != '0))
                 | (cls.reads_rs2 & (cnt_rs2 != '0))
                 | (cls.writes_rd & rd_full)
                 | at_limit;
      issue_fire = 1'b0;
      trap_fire  = 1'b0;
      case (state_q)
         SB_RUN: begin
            issue_fire = dec_valid & exe_ready & ~cls.serial & ~dec_illegal & ~hazard;
         end
         SB_DRAIN: begin
            if (inflight_q == '0) begin
               if (drain_ill_q) begin
                  trap_fire = 1'b1;
               end else begin
                  issue_fire = dec_valid & exe_ready;
               end
            end
         end
         default: begin
            issue_fire = 1'b0;
            trap_fire  = 1'b0;
         end
      endcase
      issue_fire = issue_fire & active;
      trap_fire  = trap_fire & active;

      retire_ok = ret_valid & (inflight_q != '0);
      inc_en    = issue_fire & cls.writes_rd & (dec_rd != '0);
      dec_en    = ret_valid & ret_we & (ret_rd != '0);

      if (flush) begin
         inflight_d = '0;
      end else begin
         inflight_d = inflight_q + INFL_W'(issue_fire) - INFL_W'(retire_ok);
      end

      sb_error_d = sb_error_q
                 | (ret_valid & ((inflight_q == '0) | (ret_we & (ret_rd != '0) & ret_empty)));
   end

   always_comb begin
      state_d     = state_q;
      drain_ill_d = drain_ill_q;
      case (state_q)
         SB_RUN: begin
            if (dec_valid & (dec_illegal | cls.serial)) begin
               state_d     = SB_DRAIN;
               drain_ill_d = dec_illegal;
            end
         end
         SB_DRAIN: begin
            if (trap_fire) begin
               state_d = SB_TRAP;
            end else if (issue_fire) begin
               state_d = SB_SERIAL;
            end
         end
         SB_SERIAL: begin
            if (inflight_d == '0) begin
               state_d = SB_RUN;
            end
         end
         SB_TRAP: begin
            state_d = SB_TRAP;
         end
         default: begin
            state_d = SB_RUN;
         end
      endcase
      if (flush) begin
         state_d     = SB_RUN;
         drain_ill_d = 1'b0;
      end
   end

   always_comb begin
      issue_valid  = issue_fire;
      trap_illegal = trap_fire;
      o_busy       = ~clk_en | (state_q != SB_RUN) | (dec_valid & ~issue_fire);
      inflight     = inflight_q;
      sb_error     = sb_error_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= SB_RUN;
         drain_ill_q <= 1'b0;
         inflight_q  <= '0;
         sb_error_q  <= 1'b0;
      end else if (clk_en) begin
         state_q     <= state_d;
         drain_ill_q <= drain_ill_d;
         inflight_q  <= inflight_d;
         sb_error_q  <= sb_error_d;
      end
   end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: stimulus rows push expected issue and
// trap cycles into queues that a negedge monitor pops and compares.
module tb_issue_scoreboard;
   import issue_scoreboard_pkg::*;

   logic     clk = 1'b0;
   logic     rst = 1'b1;
   logic     clk_en = 1'b1;
   logic     dec_valid = 1'b0;
   opcodes_t dec_opcode = OP_NOP;
   logic [4:0] dec_rs1 = '0;
   logic [4:0] dec_rs2 = '0;
   logic [4:0] dec_rd = '0;
   logic     dec_illegal = 1'b0;
   logic     exe_ready = 1'b0;
   logic     issue_valid;
   logic     o_busy;
   logic     ret_valid = 1'b0;
   logic     ret_we = 1'b0;
   logic [4:0] ret_rd = '0;
   logic     flush = 1'b0;
   logic     trap_illegal;
   logic [2:0] inflight;
   logic     sb_error;

   bit rstNext = 1'b1;
   bit clkEnNext = 1'b1;
   int cyc = 0;
   int testsRun = 0;
   int testsFailed = 0;
   int expIssueQ[$];
   int expTrapQ[$];

   issue_scoreboard #(
      .MAX_INFLIGHT(4),
      .CNT_W(2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .clk_en       (clk_en),
      .dec_valid    (dec_valid),
      .dec_opcode   (dec_opcode),
      .dec_rs1      (dec_rs1),
      .dec_rs2      (dec_rs2),
      .dec_rd       (dec_rd),
      .dec_illegal  (dec_illegal),
      .exe_ready    (exe_ready),
      .issue_valid  (issue_valid),
      .o_busy       (o_busy),
      .ret_valid    (ret_valid),
      .ret_we       (ret_we),
      .ret_rd       (ret_rd),
      .flush        (flush),
      .trap_illegal (trap_illegal),
      .inflight     (inflight),
      .sb_error     (sb_error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      testsRun++;
      if (actual != expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // One row = one clock cycle of inputs plus whether an issue/trap is due in it.
   task automatic applyStimulus(input bit v, input opcodes_t op, input int rs1, input int rs2,
                                input int rd, input bit ill, input bit rdy, input bit rv,
                                input int rrd, input bit fl, input bit expI, input bit expT);
      @(posedge clk);
      #1;
      rst         = rstNext;
      clk_en      = clkEnNext;
      dec_valid   = v;
      dec_opcode  = op;
      dec_rs1     = 5'(rs1);
      dec_rs2     = 5'(rs2);
      dec_rd      = 5'(rd);
      dec_illegal = ill;
      exe_ready   = rdy;
      ret_valid   = rv;
      ret_we      = rv;
      ret_rd      = 5'(rrd);
      flush       = fl;
      if (expI) expIssueQ.push_back(cyc);
      if (expT) expTrapQ.push_back(cyc);
      #3;
   endtask

   task automatic idleCycle(input bit fl);
      applyStimulus(1'b0, OP_NOP, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, fl, 1'b0, 1'b0);
   endtask

   // Monitor: every DUT issue/trap must match the oldest expected cycle.
   always @(negedge clk) begin
      if (issue_valid) begin
         if (expIssueQ.size() == 0) checkOutput("issue_unexpected", cyc, -1);
         else checkOutput("issue_cycle", cyc, expIssueQ.pop_front());
      end
      while (expIssueQ.size() > 0 && expIssueQ[0] < cyc)
         checkOutput("issue_missed", cyc, expIssueQ.pop_front());
      if (trap_illegal) begin
         if (expTrapQ.size() == 0) checkOutput("trap_unexpected", cyc, -1);
         else checkOutput("trap_cycle", cyc, expTrapQ.pop_front());
      end
      while (expTrapQ.size() > 0 && expTrapQ[0] < cyc)
         checkOutput("trap_missed", cyc, expTrapQ.pop_front());
   end

   initial begin
      rstNext = 1'b1;
      idleCycle(1'b0);
      idleCycle(1'b0);
      rstNext = 1'b0;
      idleCycle(1'b0);
      checkOutput("reset_inflight", int'(inflight), 0);
      checkOutput("reset_busy", int'(o_busy), 0);
      checkOutput("reset_issue", int'(issue_valid), 0);
      checkOutput("reset_trap", int'(trap_illegal), 0);
      checkOutput("reset_sb_error", int'(sb_error), 0);

      // RAW: ADD x3,x1,x2 then ADD x4,x3,x3
      applyStimulus(1, OP_ADD, 1, 2, 3, 0, 1, 0, 0, 0, 1, 0);
      applyStimulus(1, OP_ADD, 3, 3, 4, 0, 1, 0, 0, 0, 0, 0);
      checkOutput("raw_stall_busy", int'(o_busy), 1);
      checkOutput("raw_inflight", int'(inflight), 1);
      applyStimulus(1, OP_ADD, 3, 3, 4, 0, 1, 1, 3, 0, 0, 0);
      checkOutput("raw_no_bypass_busy", int'(o_busy), 1);
      applyStimulus(1, OP_ADD, 3, 3, 4, 0, 1, 0, 0, 0, 1, 0);
      checkOutput("raw_inflight_after_retire", int'(inflight), 0);
      checkOutput("raw_issue_busy", int'(o_busy), 0);
      idleCycle(1'b0);
      checkOutput("raw_inflight_end", int'(inflight), 1);
      idleCycle(1'b1);

      // x0 is never tracked
      applyStimulus(1, OP_ADDI, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
      applyStimulus(1, OP_SUB, 0, 0, 5, 0, 1, 0, 0, 0, 1, 0);
      checkOutput("x0_no_stall_busy", int'(o_busy), 0);
      idleCycle(1'b0);
      checkOutput("x0_inflight", int'(inflight), 2);
      idleCycle(1'b1);

      // In-flight limit
      for (int r = 6; r < 10; r++) applyStimulus(1, OP_ADD, 1, 2, r, 0, 1, 0, 0, 0, 1, 0);
      applyStimulus(1, OP_ADD, 1, 2, 10, 0, 1, 0, 0, 0, 0, 0);
      checkOutput("limit_inflight", int'(inflight), 4);
      checkOutput("limit_busy", int'(o_busy), 1);
      applyStimulus(1, OP_ADD, 1, 2, 10, 0, 1, 1, 6, 0, 0, 0);
      checkOutput("limit_retire_same_cycle_busy", int'(o_busy), 1);
      applyStimulus(1, OP_ADD, 1, 2, 10, 0, 1, 0, 0, 0, 1, 0);
      checkOutput("limit_inflight_after_retire", int'(inflight), 3);
      idleCycle(1'b0);
      checkOutput("limit_inflight_refilled", int'(inflight), 4);
      idleCycle(1'b1);

      // CSRRW drains, issues alone, and blocks the next ADD until it retires
      applyStimulus(1, OP_ADD, 1, 2, 11, 0, 1, 0, 0, 0, 1, 0);
      applyStimulus(1, OP_ADD, 1, 2, 12, 0, 1, 0, 0, 0, 1, 0);
      applyStimulus(1, OP_CSRRW, 1, 0, 13, 0, 1, 0, 0, 0, 0, 0);
      checkOutput("csr_enter_busy", int'(o_busy), 1);
      applyStimulus(1, OP_CSRRW, 1, 0, 13, 0, 1, 1, 11, 0, 0, 0);
      checkOutput("csr_drain_inflight", int'(inflight), 2);
      applyStimulus(1, OP_CSRRW, 1, 0, 13, 0, 1, 1, 12, 0, 0, 0);
      applyStimulus(1, OP_CSRRW, 1, 0, 13, 0, 1, 0, 0, 0, 1, 0);
      checkOutput("csr_issue_inflight", int'(inflight), 0);
      applyStimulus(1, OP_ADD, 1, 2, 14, 0, 1, 0, 0, 0, 0, 0);
      checkOutput("serial_busy", int'(o_busy), 1);
      checkOutput("serial_inflight", int'(inflight), 1);
      applyStimulus(1, OP_ADD, 1, 2, 14, 0, 1, 1, 13, 0, 0, 0);
      applyStimulus(1, OP_ADD, 1, 2, 14, 0, 1, 0, 0, 0, 1, 0);
      checkOutput("serial_done_inflight", int'(inflight), 0);
      idleCycle(1'b1);

      // Illegal instruction behind one in-flight op
      applyStimulus(1, OP_ADD, 1, 2, 15, 0, 1, 0, 0, 0, 1, 0);
      applyStimulus(1, OP_ADD, 1, 2, 16, 1, 1, 0, 0, 0, 0, 0);
      checkOutput("illegal_busy", int'(o_busy), 1);
      applyStimulus(1, OP_ADD, 1, 2, 16, 1, 1, 1, 15, 0, 0, 0);
      checkOutput("illegal_wait_trap", int'(trap_illegal), 0);
      applyStimulus(1, OP_ADD, 1, 2, 16, 1, 1, 0, 0, 0, 0, 1);
      checkOutput("illegal_trap_pulse", int'(trap_illegal), 1);
      applyStimulus(1, OP_ADD, 1, 2, 16, 1, 1, 0, 0, 0, 0, 0);
      checkOutput("trap_single_cycle", int'(trap_illegal), 0);
      checkOutput("trap_busy", int'(o_busy), 1);
      idleCycle(1'b0);
      checkOutput("trap_idle_busy", int'(o_busy), 1);
      idleCycle(1'b1);
      idleCycle(1'b0);
      checkOutput("trap_flush_busy", int'(o_busy), 0);
      checkOutput("trap_flush_inflight", int'(inflight), 0);

      // Flush during SERIAL returns to RUN
      applyStimulus(1, OP_FENCE, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      applyStimulus(1, OP_FENCE, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
      idleCycle(1'b0);
      checkOutput("fence_serial_busy", int'(o_busy), 1);
      checkOutput("fence_serial_inflight", int'(inflight), 1);
      idleCycle(1'b1);
      idleCycle(1'b0);
      checkOutput("fence_flush_busy", int'(o_busy), 0);
      checkOutput("fence_flush_inflight", int'(inflight), 0);
      applyStimulus(1, OP_ADD, 1, 2, 3, 0, 1, 0, 0, 0, 1, 0);

      // clk_en low freezes everything and blocks issue
      clkEnNext = 1'b0;
      applyStimulus(1, OP_ADD, 1, 2, 4, 0, 1, 0, 0, 0, 0, 0);
      checkOutput("clken_busy", int'(o_busy), 1);
      clkEnNext = 1'b1;
      applyStimulus(1, OP_ADD, 1, 2, 4, 0, 1, 0, 0, 0, 1, 0);
      checkOutput("clken_frozen_inflight", int'(inflight), 1);
      idleCycle(1'b1);

      // Pending counter saturation on the same destination
      for (int k = 0; k < 3; k++) applyStimulus(1, OP_ADD, 1, 2, 20, 0, 1, 0, 0, 0, 1, 0);
      applyStimulus(1, OP_ADD, 1, 2, 20, 0, 1, 0, 0, 0, 0, 0);
      checkOutput("sat_busy", int'(o_busy), 1);
      checkOutput("sat_inflight", int'(inflight), 3);
      applyStimulus(1, OP_ADD, 1, 2, 21, 0, 1, 0, 0, 0, 1, 0);
      idleCycle(1'b1);

      // Retire with nothing in flight
      applyStimulus(0, OP_NOP, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0);
      idleCycle(1'b0);
      checkOutput("sb_error_set", int'(sb_error), 1);
      checkOutput("sb_error_inflight", int'(inflight), 0);
      idleCycle(1'b1);
      idleCycle(1'b0);
      checkOutput("sb_error_sticky_flush", int'(sb_error), 1);
      rstNext = 1'b1;
      idleCycle(1'b0);
      rstNext = 1'b0;
      idleCycle(1'b0);
      checkOutput("sb_error_reset", int'(sb_error), 0);

      idleCycle(1'b0);
      idleCycle(1'b0);
      checkOutput("issue_queue_left", expIssueQ.size(), 0);
      checkOutput("trap_queue_left", expTrapQ.size(), 0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
